// File: rtl/encoder_rr_5bit.sv
// encoder_rr_5bit: sequential round-robin 32-to-5 encoder.
// Scans the request vector from the round-robin pointer upward, wrapping at the
// top. It registers the selected index behind a valid/ready output stage.
// Optional feature macro: ENC_ONEHOT_OUT_EN adds a registered one-hot GRANT output.
module encoder_rr_5bit #(
    parameter  int IDX_W = 5,
    localparam int N     = 1 << IDX_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N-1:0]     REQ,
    input  logic             OUT_READY,
    output logic             OUT_VALID,
    output logic [IDX_W-1:0] INDEX,
`ifdef ENC_ONEHOT_OUT_EN
    output logic [N-1:0]     GRANT,
`endif
    output logic [IDX_W-1:0] PTR
);

    logic             valid_q;
    logic [IDX_W-1:0] index_q;
    logic [IDX_W-1:0] ptr_q;

    logic             accept;
    logic             load;
    logic             any_req;
    logic [IDX_W-1:0] nptr;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [IDX_W-1:0] scan_idx;

    assign accept  = valid_q & OUT_READY;
    assign load    = ~valid_q | OUT_READY;
    assign any_req = |REQ;
    assign nptr    = accept ? (index_q + IDX_W'(1)) : ptr_q;

    // Circular scan from nptr: first asserted request wins (index math wraps mod N).
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            scan_idx = IDX_W'(nptr + IDX_W'(i));
            if (!found && REQ[scan_idx]) begin
                pick  = scan_idx;
                found = 1'b1;
            end
        end
    end

    // Output register and pointer; the output holds while stalled.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q <= 1'b0;
            index_q <= '0;
            ptr_q   <= '0;
        end else begin
            if (accept) begin
                ptr_q <= nptr;
            end
            if (load) begin
                valid_q <= any_req;
                if (any_req) begin
                    index_q <= pick;
                end
            end
        end
    end

`ifdef ENC_ONEHOT_OUT_EN
    logic [N-1:0] grant_q;

    // One-hot view of the selection, zero whenever no valid output is held.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            grant_q <= '0;
        end else if (load) begin
            grant_q <= any_req ? (N'(1) << pick) : '0;
        end
    end

    assign GRANT = grant_q;
`endif

    assign OUT_VALID = valid_q;
    assign INDEX     = index_q;
    assign PTR       = ptr_q;

endmodule

// File: tb/tb_encoder_rr_5bit.sv
// tb_encoder_rr_5bit: directed and random stimulus for encoder_rr_5bit.
// This bench checks the design against a reference model of the round-robin rules.
// It also checks GRANT when ENC_ONEHOT_OUT_EN is defined.
module tb_encoder_rr_5bit;

    logic        CLK;
    logic        RST_N;
    logic [31:0] REQ;
    logic        OUT_READY;
    logic        OUT_VALID;
    logic [4:0]  INDEX;
    logic [4:0]  PTR;
`ifdef ENC_ONEHOT_OUT_EN
    logic [31:0] GRANT;
`endif

    encoder_rr_5bit #(.IDX_W(5)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ       (REQ),
        .OUT_READY (OUT_READY),
        .OUT_VALID (OUT_VALID),
        .INDEX     (INDEX),
`ifdef ENC_ONEHOT_OUT_EN
        .GRANT     (GRANT),
`endif
        .PTR       (PTR)
    );

    // Free-running clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model state: integers and plain modular arithmetic.
    bit m_valid = 1'b0;
    int m_index = 0;
    int m_ptr   = 0;

    task automatic check_outputs(input string tag);
        logic [4:0] exp_index;
        logic [4:0] exp_ptr;
        exp_index = 5'(m_index);
        exp_ptr   = 5'(m_ptr);
        checks++;
        assert (OUT_VALID === m_valid) else begin
            errors++;
            $error("FAIL %s valid: got %b want %b", tag, OUT_VALID, m_valid);
        end
        checks++;
        assert (INDEX === exp_index) else begin
            errors++;
            $error("FAIL %s index: got %0d want %0d", tag, INDEX, exp_index);
        end
        checks++;
        assert (PTR === exp_ptr) else begin
            errors++;
            $error("FAIL %s ptr: got %0d want %0d", tag, PTR, exp_ptr);
        end
`ifdef ENC_ONEHOT_OUT_EN
        begin
            logic [31:0] exp_grant;
            exp_grant = m_valid ? (32'd1 << m_index) : 32'd0;
            checks++;
            assert (GRANT === exp_grant) else begin
                errors++;
                $error("FAIL %s grant: got %h want %h", tag, GRANT, exp_grant);
            end
        end
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic [31:0] r, input logic rdy, input logic rn, input string tag);
        bit acc;
        bit ld;
        int np;
        int pk;
        bit found;
        REQ       = r;
        OUT_READY = rdy;
        RST_N     = rn;
        acc   = m_valid && rdy;
        ld    = !m_valid || rdy;
        np    = acc ? (m_index + 1) % 32 : m_ptr;
        found = 1'b0;
        pk    = 0;
        for (int k = 0; k < 32; k++) begin
            if (!found && r[(np + k) % 32]) begin
                pk    = (np + k) % 32;
                found = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
        if (!rn) begin
            m_valid = 1'b0;
            m_index = 0;
            m_ptr   = 0;
        end else begin
            m_ptr = np;
            if (ld) begin
                m_valid = (r != 32'd0);
                if (r != 32'd0) m_index = pk;
            end
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [31:0] r;
        REQ       = 32'hFFFF_FFFF;
        OUT_READY = 1'b0;
        RST_N     = 1'b0;

        // Reset held with all requests asserted.
        step(32'hFFFF_FFFF, 1'b1, 1'b0, "reset0");
        step(32'hFFFF_FFFF, 1'b1, 1'b0, "reset1");
        step(32'hFFFF_FFFF, 1'b0, 1'b1, "release");

        // Single request.
        step(32'h0000_0000, 1'b1, 1'b0, "reset2");
        step(32'h0000_0400, 1'b1, 1'b1, "single_sel");
        step(32'h0000_0400, 1'b1, 1'b1, "single_acc");
        step(32'h0000_0000, 1'b1, 1'b1, "single_drop");
        step(32'h0000_0000, 1'b1, 1'b1, "idle");

        // Round-robin between bits 0 and 31.
        step(32'h0000_0000, 1'b1, 1'b0, "reset3");
        for (int i = 0; i < 6; i++) step(32'h8000_0001, 1'b1, 1'b1, "wrap_pair");

        // Fairness: every index in order, then back to 0.
        step(32'h0000_0000, 1'b1, 1'b0, "reset4");
        for (int i = 0; i < 34; i++) step(32'hFFFF_FFFF, 1'b1, 1'b1, "fair_all");

        // Backpressure: the selection holds through a REQ change.
        step(32'h0000_0000, 1'b1, 1'b0, "reset5");
        for (int i = 0; i < 5; i++) step(32'h0000_00F0, 1'b0, 1'b1, "bp_hold");
        for (int i = 0; i < 2; i++) step(32'h0000_0100, 1'b0, 1'b1, "bp_reqchg");
        step(32'h0000_0100, 1'b1, 1'b1, "bp_accept");
        step(32'h0000_0000, 1'b1, 1'b1, "bp_drain");

        // Pointer at 31 with index 30 valid; the next scan wraps 31->0->1.
        step(32'h0000_0000, 1'b1, 1'b0, "reset6");
        for (int i = 0; i < 3; i++) step(32'h4000_0000, 1'b1, 1'b1, "sim_prep");
        step(32'h4000_0002, 1'b1, 1'b1, "sim_wrap");
        step(32'h4000_0002, 1'b0, 1'b1, "sim_stall");
        step(32'h4000_0002, 1'b0, 1'b0, "sim_reset");

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: r = 32'd0;
                1: r = 32'd1 << $urandom_range(0, 31);
                default: r = $urandom();
            endcase
            step(r, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) != 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
